// File: rtl/alu.sv
// alu: 8-bit registered arithmetic/logic unit (datapath execute stage).
// One result per clock, one-cycle latency, synchronous active-high reset.
// Optional build macro ALU_FLAGS_EN adds registered carry/borrow and zero
// flag outputs; without it only the registered result is produced.
module alu #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       opcode,
`ifdef ALU_FLAGS_EN
   output logic [WIDTH-1:0] out,
   output logic             carry,
   output logic             zero
`else
   output logic [WIDTH-1:0] out
`endif
);

   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;
   localparam logic [2:0] OP_AND = 3'd2;
   localparam logic [2:0] OP_OR  = 3'd3;
   localparam logic [2:0] OP_XOR = 3'd4;
   localparam logic [2:0] OP_NOT = 3'd5;
   localparam logic [2:0] OP_SHL = 3'd6;
   localparam logic [2:0] OP_SHR = 3'd7;

   logic [WIDTH-1:0] res_s;
   logic [2:0]       shamt_s;

   // only the low three bits of b steer the shifter
   assign shamt_s = b[2:0];

   // combinational result selection; every opcode yields a defined value
   always_comb begin
      res_s = {WIDTH{1'b0}};
      case (opcode)
         OP_ADD:  res_s = a + b;
         OP_SUB:  res_s = a - b;
         OP_AND:  res_s = a & b;
         OP_OR:   res_s = a | b;
         OP_XOR:  res_s = a ^ b;
         OP_NOT:  res_s = ~a;
         OP_SHL:  res_s = a << shamt_s;
         OP_SHR:  res_s = a >> shamt_s;
         default: res_s = {WIDTH{1'b0}};
      endcase
   end

   // result register; reset has priority over any opcode
   always_ff @(posedge clk) begin
      if (rst) begin
         out <= {WIDTH{1'b0}};
      end else begin
         out <= res_s;
      end
   end

`ifdef ALU_FLAGS_EN
   logic carry_s;
   logic zero_s;

   // last bit shifted out of a left shift is a[WIDTH-amt]; amt 0 selects
   // a bit position past the top, so the one-hot pick is empty and gives 0
   function automatic logic shl_carry(input logic [WIDTH-1:0] val,
                                      input logic [2:0]       amt);
      logic [WIDTH-1:0] pick;
      pick = WIDTH'(1'b1) << (WIDTH - int'(amt));
      return |(val & pick);
   endfunction

   // carry/borrow and zero flags derived from the same cycle's operands
   always_comb begin
      carry_s = 1'b0;
      case (opcode)
         OP_ADD:  carry_s = (res_s < a);   // wrapped sum is smaller than an addend
         OP_SUB:  carry_s = (a < b);       // borrow
         OP_SHL:  carry_s = shl_carry(a, shamt_s);
         default: carry_s = 1'b0;
      endcase
      zero_s = (res_s == {WIDTH{1'b0}});
   end

   // flag registers, updated alongside out
   always_ff @(posedge clk) begin
      if (rst) begin
         carry <= 1'b0;
         zero  <= 1'b0;
      end else begin
         carry <= carry_s;
         zero  <= zero_s;
      end
   end
`endif

endmodule

// File: tb/tb_alu.sv
// tb_alu: table-driven and randomized scoreboard bench for alu.
module tb_alu;

   logic       clk;
   logic       rst;
   logic [7:0] a;
   logic [7:0] b;
   logic [2:0] opcode;
   logic [7:0] out;
`ifdef ALU_FLAGS_EN
   logic       carry;
   logic       zero;
`endif

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic       rst;
      logic [7:0] a;
      logic [7:0] b;
      logic [2:0] op;
      logic [7:0] exp_out;
      logic       exp_c;
      logic       exp_z;
   } vec_t;

   typedef struct {
      logic [7:0] out;
      logic       c;
      logic       z;
   } exp_t;

   exp_t sb[$];
   vec_t vecs[16];

   alu #(.WIDTH(8)) dut (
      .clk    (clk),
      .rst    (rst),
      .a      (a),
      .b      (b),
      .opcode (opcode),
`ifdef ALU_FLAGS_EN
      .out    (out),
      .carry  (carry),
      .zero   (zero)
`else
      .out    (out)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // independent reference: wide arithmetic, direct bit indexing
   function automatic exp_t model(input logic r, input logic [7:0] x,
                                  input logic [7:0] y, input logic [2:0] op);
      exp_t e;
      logic [8:0] wide;
      int sh;
      e.out = 8'h00; e.c = 1'b0; e.z = 1'b0;
      if (r) return e;
      sh = int'(y[2:0]);
      case (op)
         3'd0: begin wide = {1'b0, x} + {1'b0, y}; e.out = wide[7:0]; e.c = wide[8]; end
         3'd1: begin e.out = 8'(x - y); e.c = (x < y); end
         3'd2: e.out = x & y;
         3'd3: e.out = x | y;
         3'd4: e.out = x ^ y;
         3'd5: e.out = ~x;
         3'd6: begin
            e.out = 8'((16'(x) << sh) & 16'h00ff);
            e.c = (sh == 0) ? 1'b0 : x[8 - sh];
         end
         default: e.out = 8'(x >> sh);
      endcase
      e.z = (e.out == 8'h00);
      return e;
   endfunction

   task automatic drive(input logic r, input logic [7:0] x, input logic [7:0] y,
                        input logic [2:0] op, input exp_t e);
      @(negedge clk);
      rst = r; a = x; b = y; opcode = op;
      sb.push_back(e);
   endtask

   task automatic sample(input string name);
      exp_t e;
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         checks++; errors++;
         $display("FAIL %s: scoreboard empty", name);
         return;
      end
      e = sb.pop_front();
      checks++;
      if (out !== e.out) begin
         errors++;
         $display("FAIL %s out: got %02h expected %02h", name, out, e.out);
      end
`ifdef ALU_FLAGS_EN
      checks++;
      if (carry !== e.c) begin
         errors++;
         $display("FAIL %s carry: got %0b expected %0b", name, carry, e.c);
      end
      checks++;
      if (zero !== e.z) begin
         errors++;
         $display("FAIL %s zero: got %0b expected %0b", name, zero, e.z);
      end
`endif
   endtask

   initial begin
      exp_t e;
      logic [7:0] ra;
      logic [7:0] rb;
      logic       rr;
      rst = 1'b1; a = 8'h00; b = 8'h00; opcode = 3'd0;

      //           rst   a      b      op    out    c     z
      vecs[0]  = '{1'b1, 8'hFF, 8'hFF, 3'd0, 8'h00, 1'b0, 1'b0};
      vecs[1]  = '{1'b0, 8'd200, 8'd100, 3'd0, 8'h2C, 1'b1, 1'b0};
      vecs[2]  = '{1'b0, 8'h80, 8'h80, 3'd0, 8'h00, 1'b1, 1'b1};
      vecs[3]  = '{1'b0, 8'd5,  8'd10, 3'd1, 8'hFB, 1'b1, 1'b0};
      vecs[4]  = '{1'b0, 8'd10, 8'd5,  3'd1, 8'h05, 1'b0, 1'b0};
      vecs[5]  = '{1'b0, 8'hF0, 8'h3C, 3'd2, 8'h30, 1'b0, 1'b0};
      vecs[6]  = '{1'b0, 8'hF0, 8'h0C, 3'd3, 8'hFC, 1'b0, 1'b0};
      vecs[7]  = '{1'b0, 8'hAA, 8'hFF, 3'd4, 8'h55, 1'b0, 1'b0};
      vecs[8]  = '{1'b0, 8'h0F, 8'h33, 3'd5, 8'hF0, 1'b0, 1'b0};
      vecs[9]  = '{1'b0, 8'h81, 8'h01, 3'd6, 8'h02, 1'b1, 1'b0};
      vecs[10] = '{1'b0, 8'h81, 8'h03, 3'd7, 8'h10, 1'b0, 1'b0};
      vecs[11] = '{1'b0, 8'h81, 8'h00, 3'd6, 8'h81, 1'b0, 1'b0};
      vecs[12] = '{1'b0, 8'h03, 8'hF9, 3'd6, 8'h06, 1'b0, 1'b0};
      vecs[13] = '{1'b0, 8'hFF, 8'h0F, 3'd7, 8'h01, 1'b0, 1'b0};
      vecs[14] = '{1'b0, 8'h00, 8'h00, 3'd1, 8'h00, 1'b0, 1'b1};
      vecs[15] = '{1'b0, 8'hFF, 8'h01, 3'd0, 8'h00, 1'b1, 1'b1};

      for (int i = 0; i < 16; i++) begin
         e.out = vecs[i].exp_out; e.c = vecs[i].exp_c; e.z = vecs[i].exp_z;
         drive(vecs[i].rst, vecs[i].a, vecs[i].b, vecs[i].op, e);
         sample($sformatf("vec%0d", i));
      end

      // back-to-back opcode sweep with random operands, reset mid-sweep
      for (int i = 0; i < 40; i++) begin
         ra = 8'($urandom_range(0, 255));
         rb = 8'($urandom_range(0, 255));
         rr = (i == 19);
         drive(rr, ra, rb, 3'(i % 8), model(rr, ra, rb, 3'(i % 8)));
         sample($sformatf("sweep%0d", i));
      end

      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d left expected 0", sb.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
